// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter, one byte per idle-high frame
//
// Serializes tx_data into: start bit '0', DATA_BITS data bits LSB first,
// optional even-parity bit, stop bit '1'. Each bit lasts CLKS_PER_BIT clk
// cycles. Frame length is (DATA_BITS+2)*CLKS_PER_BIT cycles, plus one more
// bit period when parity is compiled in.
//
// Optional feature macro: UART_TX_PARITY_EN (inserts the PARITY state).
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   tx_data    in   payload, latched only when a frame is accepted
//   tx_start   in   level request; accepted only while idle
//   serial_out out  registered serial line, idles high
//   tx_busy    out  high from the accept edge until the stop bit ends
//   tx_done    out  one-cycle pulse in the cycle after the stop bit ends

module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 serial_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  // The shift register is consumed during DATA, so parity is captured at
  // accept time from the untouched payload.
  logic                 parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      serial_out <= serial_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic. serial_d is the value the line will carry after the
  // coming edge, so every state transition also picks the next bit value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    serial_d = serial_out;
    busy_d   = tx_busy;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // The bit-period counter free-runs through every non-idle state and
    // wraps exactly at the bit boundary.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (tx_start) begin
          shreg_d  = tx_data;
          serial_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end

      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = shreg_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            // bit 1 becomes the LSB after this shift
            serial_d = shreg_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
`endif

      STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (frame model + directed vectors)

module tb_uart_tx;

  localparam int DB  = 8;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = DB + 3;
  localparam logic [NB-1:0] PAT_A5 = 11'b1_0_10100101_0;
  localparam logic [NB-1:0] PAT_55 = 11'b1_0_01010101_0;
  localparam logic [NB-1:0] PAT_07 = 11'b1_1_00000111_0;
  localparam logic [NB-1:0] PAT_03 = 11'b1_0_00000011_0;
`else
  localparam int NB  = DB + 2;
  localparam logic [NB-1:0] PAT_A5 = 10'b1_10100101_0;
  localparam logic [NB-1:0] PAT_55 = 10'b1_01010101_0;
`endif
  localparam int FRAME = NB * CPB;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          tx_start = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          serial_out;
  logic          tx_busy;
  logic          tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic logic [NB-1:0] frame_bits(input logic [DB-1:0] d);
    logic [NB-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[DB+1] = ^d;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  // Model: queue of expected {serial, busy, done} per cycle. A request is
  // honoured only when nothing is pending; the done cycle is the last entry.
  logic [2:0]    mq[$];
  logic [2:0]    expv = 3'b100;
  logic [NB-1:0] mfr;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      expv = 3'b100;
    end else begin
      if (mq.size() == 0 && tx_start) begin
        mfr = frame_bits(tx_data);
        for (int b = 0; b < NB; b++)
          for (int c = 0; c < CPB; c++) mq.push_back({mfr[b], 2'b10});
        mq.push_back(3'b101);
      end
      if (mq.size() != 0) expv = mq.pop_front();
      else expv = 3'b100;
    end
  end

  always @(negedge clk) begin
    chk("model serial_out", int'(serial_out), int'(expv[2]));
    chk("model tx_busy", int'(tx_busy), int'(expv[1]));
    chk("model tx_done", int'(tx_done), int'(expv[0]));
  end

  // Pulse tx_start for one edge and record the frame against literals.
  task automatic send_capture(input logic [DB-1:0] d, input logic [NB-1:0] pat,
                              input string tag);
    int busy_n, done_n, done_at;
    logic [NB-1:0] got;
    @(posedge clk); #2;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; got = '0;
    for (int k = 0; k < FRAME + 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (tx_busy) busy_n++;
      if (tx_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if ((k % CPB) == CPB / 2 && (k / CPB) < NB) got[k/CPB] = serial_out;
    end
    chk({tag, " bits"}, int'(got), int'(pat));
    chk({tag, " busy cycles"}, busy_n, FRAME);
    chk({tag, " done count"}, done_n, 1);
    chk({tag, " done cycle"}, done_at, FRAME);
  endtask

  initial begin
    int trans, busy_seen, done_seen, rises, t1, t2;
    logic prev_s, prev_b;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset serial_out", int'(serial_out), 1);
    chk("reset tx_busy", int'(tx_busy), 0);
    chk("reset tx_done", int'(tx_done), 0);
    #1 n_rst = 1'b1;
    trans = 0; busy_seen = 0; done_seen = 0; prev_s = serial_out;
    repeat (200) begin
      @(posedge clk); #1;
      if (serial_out != prev_s) trans++;
      prev_s = serial_out;
      if (tx_busy) busy_seen++;
      if (tx_done) done_seen++;
    end
    chk("idle transitions", trans, 0);
    chk("idle busy", busy_seen, 0);
    chk("idle done", done_seen, 0);

    // Single frame
    send_capture(8'hA5, PAT_A5, "frame A5");

    // Start while busy: second request at cycle 40 is dropped
    @(posedge clk); #2;
    tx_data = 8'hA5; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    tx_data = 8'h3C; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    done_seen = 0; rises = 0; prev_b = tx_busy;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx_done) done_seen++;
      if (tx_busy && !prev_b) rises++;
      prev_b = tx_busy;
    end
    chk("busy-start done count", done_seen, 1);
    chk("busy-start extra frames", rises, 0);

    // Back-to-back with tx_start held high
    @(posedge clk); #2;
    tx_data = 8'h00; tx_start = 1'b1;
    t1 = -1; t2 = -1;
    for (int k = 0; k < 3 * FRAME && t2 < 0; k++) begin
      @(posedge clk); #1;
      if (k == 2) tx_data = 8'hFF;
      if (tx_done) begin
        if (t1 < 0) begin
          t1 = k;
          @(posedge clk); #1;
          k++;
          tx_start = 1'b0;
        end else begin
          t2 = k;
        end
      end
    end
    tx_start = 1'b0;
    chk("b2b first done seen", int'(t1 >= 0), 1);
    chk("b2b done spacing", t2 - t1, FRAME + 1);
    repeat (20) @(posedge clk);

    // Reset during data bit 3 of 8'h0F
    @(posedge clk); #2;
    tx_data = 8'h0F; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (44) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("async rst serial_out", int'(serial_out), 1);
    chk("async rst tx_busy", int'(tx_busy), 0);
    chk("async rst tx_done", int'(tx_done), 0);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_done) done_seen++;
    end
    chk("post-reset no done", done_seen, 0);
    send_capture(8'h55, PAT_55, "frame 55");

`ifdef UART_TX_PARITY_EN
    send_capture(8'h07, PAT_07, "parity 07");
    send_capture(8'h03, PAT_03, "parity 03");
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that pairs with the UART RX path.
- Serializes one parallel byte into an idle-high asynchronous frame: start bit '0', data LSB first, optional parity, stop bit '1'.
- Bit timing comes from an internal clock-cycles-per-bit counter.
- Sits between the host-side data source and the serial line that the RX start-bit detector samples.

Parameters:
- DATA_BITS, 8: payload bits per frame; legal range 5..9.
- CLKS_PER_BIT, 10: clk cycles per serial bit period; must be at least 2.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_data  input  DATA_BITS  payload, sampled only when a frame is accepted.
- tx_start  input  1  request to send tx_data; level-sampled each rising edge.
- serial_out  output  1  serial line, idle '1'; driven from a register.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock (clk); reset n_rst is asynchronous, active-low.
- Reset values: serial_out=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0, shift register 0.
- Reset mid-frame: all of the above take effect immediately on n_rst falling, independent of clk. The frame is abandoned and no tx_done is issued.
- States: IDLE, START, DATA, PARITY (only if the optional feature is compiled in), STOP.
- Frame accept: on a rising edge with state=IDLE and tx_start=1, in the same edge:
  - tx_data is latched into the shift register.
  - serial_out becomes 0, tx_busy becomes 1, state becomes START, bit-period counter clears.
- Each state holds serial_out for exactly CLKS_PER_BIT cycles. The bit-period counter counts 0..CLKS_PER_BIT-1; terminal count advances the state.
- START: serial_out=0. On terminal count, go to DATA and drive shift-register bit 0.
- DATA:
  - serial_out = current LSB of the shift register.
  - On each terminal count the register shifts right and the bit index increments.
  - After bit DATA_BITS-1 completes, go to PARITY if enabled, otherwise STOP.
- STOP: serial_out=1. On terminal count:
  - state returns to IDLE, tx_busy drops to 0, tx_done=1 for exactly that one following cycle.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled. For 8N1 at 10 clocks per bit this is 100 cycles, from the accept edge to the tx_busy falling edge.
- Ignored input changes:
  - tx_start while tx_busy=1 is ignored, not queued.
  - Changes to tx_data mid-frame do not affect the frame in progress.
- Back-to-back: in the tx_done cycle state=IDLE, so a tx_start high in that cycle is accepted on the next edge. Minimum idle gap between the stop bit and the next start bit is 1 cycle.
- tx_start held high continuously: frames repeat back-to-back with that 1-cycle idle gap.
- Counter widths: bit-period counter is clog2(CLKS_PER_BIT) bits; bit index is clog2(DATA_BITS+1) bits. Counters never wrap mid-state.
- No glitch on serial_out: it changes only on rising clk edges, or on asynchronous reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - serial_out carries the even-parity bit, i.e. XOR of the latched payload, for CLKS_PER_BIT cycles.
  - Frame length grows by CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset/idle: assert n_rst=0 mid-simulation, then release. Required: serial_out=1, tx_busy=0, tx_done=0 throughout; no transitions for 200 cycles with tx_start=0.
- Single frame (CLKS_PER_BIT=10, tx_data=8'hA5, 1-cycle tx_start pulse). Required on serial_out:
  - 0 for 10 cycles.
  - then 1,0,1,0,0,1,0,1, each for 10 cycles.
  - then 1 for 10 cycles.
  - tx_busy high for exactly 100 cycles; single tx_done pulse on cycle 101.
- Start-while-busy: pulse tx_start with tx_data=8'h3C at cycle 40 of an 8'hA5 frame. Required: 8'hA5 frame unchanged, no second frame, exactly one tx_done.
- Back-to-back: hold tx_start=1 with tx_data=8'h00, then 8'hFF. Required: two complete frames separated by exactly 1 idle cycle at serial_out=1; two tx_done pulses 101 cycles apart.
- Reset mid-frame: drop n_rst during data bit 3 of an 8'h0F frame. Required: serial_out=1 and tx_busy=0 immediately, before the next clk edge; no tx_done; a new 8'h55 frame afterwards is correct.
- Parity, with UART_TX_PARITY_EN defined:
  - tx_data=8'h07: parity bit 1; tx_data=8'h03: parity bit 0.
  - Each frame is 110 cycles, with the parity bit driven during cycles 91-100.
